// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module  : uart_rx_fifo
// Brief   : Circular FIFO buffering uart_rx bytes toward a valid/ready consumer,
//           with sticky overflow flag. Optional stats via UART_RX_FIFO_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic [ADDR_W:0]   o_level,
  output logic              o_full,
  output logic              o_overflow,
  input  logic              i_ovf_clr,
  output logic [15:0]       o_drop_cnt,
  output logic [ADDR_W:0]   o_max_level
);

  localparam logic [ADDR_W:0] c_ONE = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic              r_full;
  logic              r_valid;
  logic              r_overflow;

  logic              w_wr_acc;
  logic              w_drop;
  logic              w_rd_fire;
  logic [ADDR_W:0]   w_wr_ptr_nxt;
  logic [ADDR_W:0]   w_rd_ptr_nxt;
  logic [ADDR_W:0]   w_level_nxt;

  // Acceptance uses the registered full, so a same-cycle read never rescues a write.
  assign w_wr_acc  = i_wr_valid && !r_full;
  assign w_drop    = i_wr_valid &&  r_full;
  assign w_rd_fire = r_valid && i_rd_ready;

  assign w_wr_ptr_nxt = w_wr_acc  ? r_wr_ptr + c_ONE : r_wr_ptr;
  assign w_rd_ptr_nxt = w_rd_fire ? r_rd_ptr + c_ONE : r_rd_ptr;

  always_comb begin
    w_level_nxt = r_level;
    case ({w_wr_acc, w_rd_fire})
      2'b10:   w_level_nxt = r_level + c_ONE;
      2'b01:   w_level_nxt = r_level - c_ONE;
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_full     <= 1'b0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_level  <= w_level_nxt;
      r_valid  <= (w_wr_ptr_nxt != w_rd_ptr_nxt);
      r_full   <= (w_wr_ptr_nxt[ADDR_W] != w_rd_ptr_nxt[ADDR_W]) &&
                  (w_wr_ptr_nxt[ADDR_W-1:0] == w_rd_ptr_nxt[ADDR_W-1:0]);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (i_ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign o_rd_data  = r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign o_rd_valid = r_valid;
  assign o_level    = r_level;
  assign o_full     = r_full;
  assign o_overflow = r_overflow;

`ifdef UART_RX_FIFO_STATS_EN
  logic [15:0]     r_drop_cnt;
  logic [ADDR_W:0] r_max_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt  <= '0;
      r_max_level <= '0;
    end else begin
      if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      if (w_level_nxt > r_max_level) begin
        r_max_level <= w_level_nxt;
      end
    end
  end

  assign o_drop_cnt  = r_drop_cnt;
  assign o_max_level = r_max_level;
`else
  assign o_drop_cnt  = '0;
  assign o_max_level = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module  : tb_uart_rx_fifo
// Brief   : Scoreboard bench for uart_rx_fifo; reads are checked by a monitor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] i_wr_data;
  logic       i_wr_valid;
  logic [7:0] o_rd_data;
  logic       o_rd_valid;
  logic       i_rd_ready;
  logic [4:0] o_level;
  logic       o_full;
  logic       o_overflow;
  logic       i_ovf_clr;
  logic [15:0] o_drop_cnt;
  logic [4:0] o_max_level;

  int n_tests = 0;
  int n_fail  = 0;
  int mdl_level = 0;
  logic [7:0] sb [$];

  uart_rx_fifo #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_data  (i_wr_data),
    .i_wr_valid (i_wr_valid),
    .o_rd_data  (o_rd_data),
    .o_rd_valid (o_rd_valid),
    .i_rd_ready (i_rd_ready),
    .o_level    (o_level),
    .o_full     (o_full),
    .o_overflow (o_overflow),
    .i_ovf_clr  (i_ovf_clr),
    .o_drop_cnt (o_drop_cnt),
    .o_max_level(o_max_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read monitor: any fire at the coming edge must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && o_rd_valid && i_rd_ready) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got %02h, scoreboard empty", o_rd_data);
      end else begin
        logic [7:0] exp_d;
        exp_d = sb.pop_front();
        if (o_rd_data !== exp_d) begin
          n_fail++;
          $display("FAIL rd_data: got %02h, expected %02h", o_rd_data, exp_d);
        end
      end
    end
  end

  // One clock of stimulus; scoreboard and level model follow the FIFO rules.
  task automatic drv(input bit wv, input logic [7:0] wd, input bit rr, input bit clr);
    bit acc, fire;
    i_wr_valid = wv;
    i_wr_data  = wd;
    i_rd_ready = rr;
    i_ovf_clr  = clr;
    acc  = wv && (mdl_level != 16);
    fire = rr && (mdl_level != 0);
    if (acc) sb.push_back(wd);
    mdl_level = mdl_level + int'(acc) - int'(fire);
    @(posedge clk);
    #1;
    i_wr_valid = 1'b0;
    i_rd_ready = 1'b0;
    i_ovf_clr  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    mdl_level = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (o_rd_valid !== 1'b0 || o_level !== 5'd0 || o_full !== 1'b0 || o_overflow !== 1'b0 ||
        o_drop_cnt !== 16'd0 || o_max_level !== 5'd0) begin
      n_fail++;
      $display("FAIL reset: valid=%b level=%0d full=%b ovf=%b drop=%0d max=%0d, expected all 0",
               o_rd_valid, o_level, o_full, o_overflow, o_drop_cnt, o_max_level);
    end
  endtask

  task automatic test_single();
    drv(1, 8'hA5, 0, 0);
    n_tests++;
    if (o_rd_valid !== 1'b1 || o_rd_data !== 8'hA5 || o_level !== 5'd1) begin
      n_fail++;
      $display("FAIL single_write: valid=%b data=%02h level=%0d, expected 1 A5 1",
               o_rd_valid, o_rd_data, o_level);
    end
    drv(0, 8'h00, 1, 0);
    n_tests++;
    if (o_rd_valid !== 1'b0 || o_level !== 5'd0) begin
      n_fail++;
      $display("FAIL single_read: valid=%b level=%0d, expected 0 0", o_rd_valid, o_level);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 16; i++) drv(1, 8'(i), 0, 0);
    n_tests++;
    if (o_full !== 1'b1 || o_level !== 5'd16 || o_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL fill: full=%b level=%0d ovf=%b, expected 1 16 0", o_full, o_level, o_overflow);
    end
    drv(1, 8'hFF, 0, 0);
    n_tests++;
    if (o_overflow !== 1'b1 || o_level !== 5'd16 || o_full !== 1'b1) begin
      n_fail++;
      $display("FAIL drop: ovf=%b level=%0d full=%b, expected 1 16 1", o_overflow, o_level, o_full);
    end
    for (int i = 0; i < 16; i++) drv(0, 8'h00, 1, 0);
    n_tests++;
    if (o_rd_valid !== 1'b0 || o_level !== 5'd0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: valid=%b level=%0d left=%0d, expected 0 0 0",
               o_rd_valid, o_level, sb.size());
    end
    drv(0, 8'h00, 0, 1);
    n_tests++;
    if (o_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clr: ovf=%b, expected 0", o_overflow);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 5; i++) drv(1, 8'h20 + 8'(i), 0, 0);
    for (int i = 0; i < 40; i++) begin
      drv(1, 8'h40 + 8'(i), 1, 0);
      n_tests++;
      if (o_level !== 5'd5 || o_rd_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_level cyc %0d: level=%0d valid=%b, expected 5 1", i, o_level, o_rd_valid);
      end
    end
    for (int i = 0; i < 5; i++) drv(0, 8'h00, 1, 0);
    n_tests++;
    if (o_level !== 5'd0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL stream_drain: level=%0d left=%0d, expected 0 0", o_level, sb.size());
    end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 16; i++) drv(1, 8'h80 + 8'(i), 0, 0);
    drv(1, 8'hEE, 1, 0);
    n_tests++;
    if (o_overflow !== 1'b1 || o_level !== 5'd15 || o_full !== 1'b0) begin
      n_fail++;
      $display("FAIL full_rw: ovf=%b level=%0d full=%b, expected 1 15 0", o_overflow, o_level, o_full);
    end
    drv(0, 8'h00, 0, 1);
    n_tests++;
    if (o_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_after_drop: ovf=%b, expected 0", o_overflow);
    end
    drv(1, 8'h90, 0, 0);
    drv(1, 8'hDD, 0, 1);
    n_tests++;
    if (o_overflow !== 1'b1 || o_level !== 5'd16) begin
      n_fail++;
      $display("FAIL set_wins: ovf=%b level=%0d, expected 1 16", o_overflow, o_level);
    end
    for (int i = 0; i < 16; i++) drv(0, 8'h00, 1, 0);
    drv(0, 8'h00, 0, 1);
    n_tests++;
    if (o_level !== 5'd0 || sb.size() != 0 || o_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL full_rw_drain: level=%0d left=%0d ovf=%b, expected 0 0 0",
               o_level, sb.size(), o_overflow);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 16; i++) drv(1, 8'h50 + 8'(i), 0, 0);
    drv(1, 8'h77, 0, 0);
    i_wr_valid = 1'b1;
    i_wr_data  = 8'h99;
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if (o_rd_valid !== 1'b0 || o_level !== 5'd0 || o_overflow !== 1'b0 || o_full !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b level=%0d ovf=%b full=%b, expected 0 0 0 0",
               o_rd_valid, o_level, o_overflow, o_full);
    end
    i_wr_valid = 1'b0;
    sb.delete();
    mdl_level = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    drv(1, 8'h3C, 0, 0);
    n_tests++;
    if (o_rd_data !== 8'h3C || o_level !== 5'd1) begin
      n_fail++;
      $display("FAIL post_reset_head: data=%02h level=%0d, expected 3C 1", o_rd_data, o_level);
    end
    drv(0, 8'h00, 1, 0);
  endtask

  task automatic test_stats();
    logic [15:0] exp_drop;
    logic [4:0]  exp_max;
`ifdef UART_RX_FIFO_STATS_EN
    exp_drop = 16'd3;
    exp_max  = 5'd16;
`else
    exp_drop = 16'd0;
    exp_max  = 5'd0;
`endif
    do_reset();
    for (int i = 0; i < 16; i++) drv(1, 8'hC0 + 8'(i), 0, 0);
    for (int i = 0; i < 3; i++) drv(1, 8'hF0 + 8'(i), 0, 0);
    n_tests++;
    if (o_drop_cnt !== exp_drop || o_max_level !== exp_max) begin
      n_fail++;
      $display("FAIL stats: drop=%0d max=%0d, expected %0d %0d", o_drop_cnt, o_max_level, exp_drop, exp_max);
    end
    for (int i = 0; i < 16; i++) drv(0, 8'h00, 1, 0);
    n_tests++;
    if (o_max_level !== exp_max || o_level !== 5'd0) begin
      n_fail++;
      $display("FAIL stats_hold: max=%0d level=%0d, expected %0d 0", o_max_level, o_level, exp_max);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    i_wr_data  = 8'h00;
    i_wr_valid = 1'b0;
    i_rd_ready = 1'b0;
    i_ovf_clr  = 1'b0;
    test_reset();
    test_single();
    test_fill_overflow();
    test_stream();
    test_full_rw();
    test_async_reset();
    test_stats();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d entries, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
